// File: rtl/seg_scan_pkg.sv
// ============================================================================
//  Module   : seg_scan_pkg
//  Purpose  : Shared types and constants for the multiplexed 7-segment
//             scan controller: segment pattern table, FSM state encoding
//             and default timing constants.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package seg_scan_pkg;

    // Scan FSM states
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } scan_state_t;

    // Default slot length and blanking interval (clk cycles)
    localparam int c_default_div          = 50000;
    localparam int c_default_blank_cycles = 2;

    // Hex digit 0..F to segments g..a (bit 6 = g, bit 0 = a), entry 0 at [0]
    localparam logic [15:0][6:0] c_seg_table = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

endpackage : seg_scan_pkg

`default_nettype wire

// File: rtl/seg_hex_decode.sv
// ============================================================================
//  Module   : seg_hex_decode
//  Purpose  : Combinational hex nibble to 7-segment decoder (g..a).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg_hex_decode
    import seg_scan_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_segs
);

    // Straight table lookup
    assign o_segs = c_seg_table[i_nibble];

endmodule : seg_hex_decode

`default_nettype wire

// File: rtl/seg_scan_ctrl.sv
// ============================================================================
//  Module   : seg_scan_ctrl
//  Purpose  : Time-multiplexed hex display scanner. Each digit gets a slot of
//             DIV cycles, the first BLANK_CYCLES of which are dark to avoid
//             ghosting. New display values are loaded through a one-deep
//             shadow register and committed only at a frame boundary while
//             scanning, so a frame never mixes old and new digits.
//  Options  : SEG_SCAN_LEADING_ZERO_BLANK_EN - when defined, digits above the
//             most significant nonzero nibble show no segments (dp kept,
//             digit 0 always shown).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg_scan_ctrl
    import seg_scan_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int DIV          = c_default_div,
    parameter int BLANK_CYCLES = c_default_blank_cycles
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [4*NUM_DIGITS-1:0] load_value,
    input  logic [NUM_DIGITS-1:0]   load_dp,
    output logic [7:0]              seg,
    output logic [NUM_DIGITS-1:0]   digit_sel_n
);

    localparam int c_presc_w = $clog2(DIV);
    localparam int c_idx_w   = $clog2(NUM_DIGITS);

    scan_state_t             r_state;
    logic [c_presc_w-1:0]    r_presc;
    logic [c_idx_w-1:0]      r_idx;
    logic [4*NUM_DIGITS-1:0] r_disp_val;
    logic [NUM_DIGITS-1:0]   r_disp_dp;
    logic [4*NUM_DIGITS-1:0] r_shadow_val;
    logic [NUM_DIGITS-1:0]   r_shadow_dp;
    logic                    r_pending;
    logic [7:0]              r_seg;
    logic [NUM_DIGITS-1:0]   r_sel_n;

    logic                    w_slot_end;
    logic                    w_frame_end;
    logic                    w_blank_slot;
    logic                    w_commit;
    logic                    w_accept;
    logic [3:0]              w_nibble;
    logic [6:0]              w_segs;
    logic                    w_lz_blank;
    logic [7:0]              w_seg_nxt;
    logic [NUM_DIGITS-1:0]   w_sel_n_nxt;

    assign w_slot_end   = (r_presc == c_presc_w'(DIV - 1));
    assign w_frame_end  = w_slot_end && (r_idx == c_idx_w'(NUM_DIGITS - 1));
    assign w_blank_slot = (r_presc < c_presc_w'(BLANK_CYCLES));

    // Idle commits immediately; scanning waits for the frame wrap
    assign w_commit = r_pending &&
                      ((r_state == ST_IDLE) || ((r_state == ST_SCAN) && w_frame_end));
    assign w_accept = load_valid && !r_pending;

    assign load_ready  = !r_pending;
    assign seg         = r_seg;
    assign digit_sel_n = r_sel_n;

    // One decoder shared by all digits, fed with the digit being scanned
    assign w_nibble = r_disp_val[{r_idx, 2'b00} +: 4];

    seg_hex_decode u_decode (
        .i_nibble (w_nibble),
        .o_segs   (w_segs)
    );

`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
    logic [c_idx_w-1:0] w_top_nz;

    // Locate the most significant nonzero digit; all-zero leaves digit 0
    always_comb begin
        w_top_nz = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_disp_val[4*i +: 4] != 4'h0) begin
                w_top_nz = c_idx_w'(i);
            end
        end
        w_lz_blank = (r_idx > w_top_nz);
    end
`else
    assign w_lz_blank = 1'b0;
`endif

    // Next-cycle output pattern for the current slot position
    always_comb begin
        w_sel_n_nxt = '1;
        w_seg_nxt   = 8'h00;
        if (!w_blank_slot) begin
            w_sel_n_nxt = ~(NUM_DIGITS'(1) << r_idx);
            w_seg_nxt   = {r_disp_dp[r_idx], (w_lz_blank ? 7'h00 : w_segs)};
        end
    end

    // Scan FSM, prescaler, digit index and registered display outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_presc <= '0;
            r_idx   <= '0;
            r_seg   <= 8'h00;
            r_sel_n <= '1;
        end else begin
            // Dropping enable darkens the display on the very next cycle
            if ((r_state == ST_SCAN) && enable) begin
                r_seg   <= w_seg_nxt;
                r_sel_n <= w_sel_n_nxt;
            end else begin
                r_seg   <= 8'h00;
                r_sel_n <= '1;
            end

            case (r_state)
                ST_IDLE: begin
                    r_presc <= '0;
                    r_idx   <= '0;
                    if (enable) begin
                        r_state <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (!enable) begin
                        r_state <= ST_IDLE;
                        r_presc <= '0;
                        r_idx   <= '0;
                    end else if (w_slot_end) begin
                        r_presc <= '0;
                        r_idx   <= (r_idx == c_idx_w'(NUM_DIGITS - 1)) ? '0 : r_idx + 1'b1;
                    end else begin
                        r_presc <= r_presc + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Load handshake: shadow capture and display commit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_disp_val   <= '0;
            r_disp_dp    <= '0;
            r_shadow_val <= '0;
            r_shadow_dp  <= '0;
            r_pending    <= 1'b0;
        end else if (w_commit) begin
            r_disp_val <= r_shadow_val;
            r_disp_dp  <= r_shadow_dp;
            r_pending  <= 1'b0;
        end else if (w_accept) begin
            r_shadow_val <= load_value;
            r_shadow_dp  <= load_dp;
            r_pending    <= 1'b1;
        end
    end

endmodule : seg_scan_ctrl

`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
// ============================================================================
//  Module   : tb_seg_scan_ctrl
//  Purpose  : Self-checking bench for seg_scan_ctrl (NUM_DIGITS=4, DIV=4,
//             BLANK_CYCLES=1). A reference model tracks elapsed scan time and
//             derives slot/digit position arithmetically.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seg_scan_ctrl;

    localparam int NUM_DIGITS   = 4;
    localparam int DIV          = 4;
    localparam int BLANK_CYCLES = 1;
    localparam int FRAME        = DIV * NUM_DIGITS;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        load_valid;
    logic        load_ready;
    logic [15:0] load_value;
    logic [3:0]  load_dp;
    logic [7:0]  seg;
    logic [3:0]  digit_sel_n;

    int n_checks;
    int n_fails;

    seg_scan_ctrl #(
        .NUM_DIGITS   (NUM_DIGITS),
        .DIV          (DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .load_value  (load_value),
        .load_dp     (load_dp),
        .seg         (seg),
        .digit_sel_n (digit_sel_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Independent copy of the hex segment table
    logic [6:0] ref_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Reference model state
    bit          m_scan;
    int          m_t;
    logic [15:0] m_disp;
    logic [3:0]  m_ddp;
    logic [15:0] m_shad;
    logic [3:0]  m_sdp;
    bit          m_pend;
    bit          m_acc;
    logic [7:0]  e_seg;
    logic [3:0]  e_sel;

    logic [19:0] prod_q [$];

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_scan = 0;
        m_t    = 0;
        m_disp = '0;
        m_ddp  = '0;
        m_shad = '0;
        m_sdp  = '0;
        m_pend = 0;
        m_acc  = 0;
        e_seg  = 8'h00;
        e_sel  = 4'hF;
    endtask

    // Apply the rules for one rising edge using the inputs held across it
    task automatic model_edge();
        int         cnt;
        int         dig;
        int         top;
        logic [6:0] s;
        m_acc = 0;
        if (!rst_n) begin
            model_reset();
            return;
        end
        e_seg = 8'h00;
        e_sel = 4'hF;
        if (m_scan && enable) begin
            cnt = m_t % DIV;
            dig = (m_t / DIV) % NUM_DIGITS;
            if (cnt >= BLANK_CYCLES) begin
                e_sel = 4'hF;
                e_sel[dig] = 1'b0;
                s = ref_tbl[m_disp[dig*4 +: 4]];
`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
                top = 0;
                for (int k = 0; k < NUM_DIGITS; k++)
                    if (m_disp[k*4 +: 4] != 4'h0) top = k;
                if (dig > top) s = 7'h00;
`else
                top = 0;
`endif
                e_seg = {m_ddp[dig], s};
            end
        end
        if (m_pend && (!m_scan || (m_t % FRAME) == FRAME - 1)) begin
            m_disp = m_shad;
            m_ddp  = m_sdp;
            m_pend = 0;
        end else if (load_valid && !m_pend) begin
            m_shad = load_value;
            m_sdp  = load_dp;
            m_pend = 1;
            m_acc  = 1;
        end
        if (m_scan) begin
            if (enable) m_t++;
            else        m_scan = 0;
        end else if (enable) begin
            m_scan = 1;
            m_t    = 0;
        end
    endtask

    task automatic check_outputs();
        chk_val("seg", {24'h0, seg}, {24'h0, e_seg});
        chk_val("digit_sel_n", {28'h0, digit_sel_n}, {28'h0, e_sel});
        chk_val("load_ready", {31'h0, load_ready}, {31'h0, !m_pend});
    endtask

    // One clock with the producer offering the head of its queue
    task automatic pcycle(input logic en);
        enable     = en;
        load_valid = (prod_q.size() > 0);
        {load_dp, load_value} = (prod_q.size() > 0) ? prod_q[0] : 20'h0;
        @(posedge clk);
        model_edge();
        if (m_acc) void'(prod_q.pop_front());
        @(negedge clk);
        check_outputs();
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
        rst_n = 1'b1;
    endtask

    initial begin
        logic        en_r;
        logic [15:0] mask;
        n_checks   = 0;
        n_fails    = 0;
        rst_n      = 1'b0;
        enable     = 1'b0;
        load_valid = 1'b0;
        load_value = '0;
        load_dp    = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check_outputs();
        rst_n = 1'b1;

        // Idle load: commits on the next edge, ready low one cycle
        prod_q.push_back({4'h0, 16'h12AF});
        repeat (4) pcycle(1'b0);

        // Scan 12AF for several frames
        repeat (40) pcycle(1'b1);

        // Mid-frame load of zero: held until the frame wraps
        repeat (5) pcycle(1'b1);
        prod_q.push_back({4'h0, 16'h0000});
        repeat (24) pcycle(1'b1);

        // Back-to-back loads in idle with valid held high
        prod_q.push_back({4'h5, 16'hBEEF});
        prod_q.push_back({4'hA, 16'h3C07});
        repeat (8) pcycle(1'b0);

        // Drop enable during digit 2, then restart
        repeat (2 * DIV + 2) pcycle(1'b1);
        repeat (3) pcycle(1'b0);
        repeat (20) pcycle(1'b1);

        // Leading-zero case with dp on the top digit
        prod_q.push_back({4'b1000, 16'h0050});
        repeat (40) pcycle(1'b1);

        // Reset mid-load while scanning discards the pending shadow
        prod_q.push_back({4'hF, 16'h9876});
        pcycle(1'b1);
        pulse_reset();
        prod_q.delete();
        repeat (20) pcycle(1'b1);

        // Randomized traffic
        en_r = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 39) == 0) en_r = ~en_r;
            if ($urandom_range(0, 19) == 0 && prod_q.size() < 3) begin
                case ($urandom_range(0, 3))
                    0:       mask = 16'h000F;
                    1:       mask = 16'h00FF;
                    2:       mask = 16'h0FFF;
                    default: mask = 16'hFFFF;
                endcase
                prod_q.push_back({4'($urandom), 16'($urandom) & mask});
            end
            if ($urandom_range(0, 599) == 0) pulse_reset();
            else                             pcycle(en_r);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule : tb_seg_scan_ctrl

`default_nettype wire

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 Parameter NUM_DIGITS, default 4, number of multiplexed hex digits, range 2..8.
REQ-002 Parameter DIV, default 50000, clk cycles per digit slot, minimum 4.
REQ-003 Parameter BLANK_CYCLES, default 2, cycles at slot start with all digits off, range 1..DIV-2.
REQ-004 Port clk input 1: single clock; all state on rising edge.
REQ-005 Port rst_n input 1: reset, asynchronous, active-low.
REQ-006 Port enable input 1: 1 = scan display, 0 = all digits off.
REQ-007 Port load_valid input 1: producer offers load_value/load_dp.
REQ-008 Port load_ready output 1: block can accept a load.
REQ-009 Port load_value input 4*NUM_DIGITS: nibble i drives digit i; digit 0 = bits [3:0].
REQ-010 Port load_dp input NUM_DIGITS: decimal point per digit.
REQ-011 Port seg output 8: active-high segments, bit7 = dp, bits 6:0 = g..a.
REQ-012 Port digit_sel_n output NUM_DIGITS: active-low digit enables, one-hot-low or all ones.

Function
REQ-013 Load accepted when load_valid && load_ready on a rising edge; value and dp captured into shadow register, pending flag set.
REQ-014 load_ready = !pending; it returns high on the cycle after a commit.
REQ-015 States IDLE and SCAN; IDLE->SCAN when enable=1, SCAN->IDLE when enable=0, each taking effect on the next edge.
REQ-016 In IDLE: prescaler and digit index held at 0, digit_sel_n all ones, seg 0; a pending shadow commits to the display register on the next edge.
REQ-017 In SCAN: prescaler counts 0..DIV-1 and wraps; at count DIV-1 the digit index advances, wrapping NUM_DIGITS-1 -> 0.
REQ-018 In SCAN, a pending shadow commits only on the edge where the index wraps NUM_DIGITS-1 -> 0 (frame boundary, tear-free).
REQ-019 seg and digit_sel_n are registered: they reflect the prescaler count and digit index of the previous cycle (1-cycle latency).
REQ-020 digit_sel_n all ones while prescaler < BLANK_CYCLES; otherwise bit[index] = 0, others 1.
REQ-021 seg = decoded display nibble[index] with bit7 = dp[index]; seg = 0 whenever digit_sel_n is all ones.
REQ-022 Decode 0-F: 3F,06,5B,4F,66,6D,7D,07,7F,6F,77,7C,39,5E,79,71 (hex, bits 6:0).
REQ-023 enable dropping mid-slot: outputs blank on the following cycle; re-enable restarts at digit 0, count 0.

Reset
REQ-024 While rst_n=0: state IDLE, prescaler 0, index 0, display and shadow 0, pending 0, load_ready 1, seg 8'h00, digit_sel_n all ones.
REQ-025 Reset mid-frame or mid-load discards any pending shadow.

Configuration
REQ-026 Macro SEG_SCAN_LEADING_ZERO_BLANK_EN defined: digits above the most significant nonzero nibble show seg bits 6:0 = 0 (dp still honoured, digit still enabled); digit 0 is never blanked.
REQ-027 Macro undefined: every digit shows its decoded nibble, including leading zeros.

Structure
REQ-028 Package seg_scan_pkg holds the 16-entry segment pattern constant, the state enum, and default DIV/BLANK_CYCLES constants.
REQ-029 Sub-module seg_hex_decode (nibble in, 7 segments out, combinational, table from REQ-022) is instantiated once and shared across all digits.

Verification (NUM_DIGITS=4, DIV=4, BLANK_CYCLES=1 unless stated)
REQ-030 Reset then enable=0, load 16'h12AF, dp=0 -> commit next edge; load_ready low 1 cycle; outputs stay blank.
REQ-031 enable=1 with display 16'h12AF -> per 4-cycle slot: 1 blank cycle, then 3 cycles of digit_sel_n=1110/seg=71, 1101/77, 1011/5B, 0111/06, repeating.
REQ-032 Mid-frame load of 16'h0000 while scanning -> load_ready low until the index wraps 3->0; no digit of that frame shows the new value.
REQ-033 load_valid held high while pending -> exactly one acceptance per commit; second value held by producer, accepted after load_ready rises.
REQ-034 enable=0 during digit 2 -> next cycle digit_sel_n=1111, seg=00; enable=1 -> scan restarts at digit 0.
REQ-035 Macro defined, display 16'h0050, dp=4'b1000 -> digits 3 and 2 show seg 8'h80 and 8'h00, digit 1 shows 6D, digit 0 shows 3F.
